// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns MEM-stage load/store requests into word-aligned
// request/grant bus transactions, stalls the pipeline meanwhile, and returns extended load data.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_R, RESP, FAULT} state_t;

    // Last WAIT_R counter value before giving up on the read.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [1:0]  off_r;
    logic [2:0]  f3_r;
    logic        is_store_r;
    logic [7:0]  cnt_r;
    logic        accept_s;
    logic        type_ok_s;
    logic        misaligned_s;
    logic        legal_s;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
        logic [31:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extract = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extract = {24'd0, shifted[7:0]};
            3'b101:  extract = {16'd0, shifted[15:0]};
            default: extract = shifted;
        endcase
    endfunction

    assign accept_s = req_valid && (req_load || req_store);

    // Classify the IDLE request: type/size legality and natural alignment.
    always_comb begin
        type_ok_s    = 1'b0;
        misaligned_s = 1'b0;
        if (req_load && !req_store) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: type_ok_s = 1'b1;
                default:                                type_ok_s = 1'b0;
            endcase
        end else if (req_store && !req_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: type_ok_s = 1'b1;
                default:                type_ok_s = 1'b0;
            endcase
        end else begin
            type_ok_s = 1'b0;
        end
        case (funct3[1:0])
            2'b01:   misaligned_s = addr[0];
            2'b10:   misaligned_s = (addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        legal_s = type_ok_s && !misaligned_s;
    end

    // Pipeline freeze: outstanding transaction, or a request being accepted this cycle.
    always_comb begin
        if ((state_r == REQ) || (state_r == WAIT_R)) begin
            stall = 1'b1;
        end else if (state_r == IDLE) begin
            stall = accept_s;
        end else begin
            stall = 1'b0;
        end
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            off_r      <= 2'd0;
            f3_r       <= 3'd0;
            is_store_r <= 1'b0;
            cnt_r      <= 8'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_be     <= 4'd0;
            bus_wdata  <= 32'd0;
            load_valid <= 1'b0;
            load_data  <= 32'd0;
            fault      <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (legal_s) begin
                            off_r      <= addr[1:0];
                            f3_r       <= funct3;
                            is_store_r <= req_store;
                            bus_req    <= 1'b1;
                            bus_we     <= req_store;
                            bus_addr   <= {addr[31:2], 2'b00};
                            bus_be     <= lane_be(funct3, addr[1:0]);
                            bus_wdata  <= req_store ? lane_wdata(funct3, wdata) : 32'd0;
                            state_r    <= REQ;
                        end else begin
                            fault   <= 1'b1;
                            state_r <= FAULT;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_be    <= 4'd0;
                        bus_wdata <= 32'd0;
                        cnt_r     <= 8'd0;
                        state_r   <= is_store_r ? RESP : WAIT_R;
                    end
                end
                WAIT_R: begin
                    // rvalid takes priority over a timeout in the same cycle.
                    if (bus_rvalid) begin
                        load_data  <= extract(f3_r, off_r, bus_rdata);
                        load_valid <= 1'b1;
                        state_r    <= RESP;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        fault   <= 1'b1;
                        state_r <= FAULT;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                RESP:    state_r <= IDLE;
                FAULT:   state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions checked against a byte-lane reference model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_load, req_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, fault;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .load_valid(load_valid), .load_data(load_data), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: sizes in bytes, lanes computed byte by byte.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input bit ld, input bit st, input logic [2:0] f3,
                                    input logic [31:0] a);
        if (ld == st) return 1'b0;
        if (f3[1:0] == 2'b11) return 1'b0;
        if (f3[2] && (st || f3[1])) return 1'b0;
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int off = a % 4;
        for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + size_of(f3));
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % size_of(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] sh, m, v;
        int sz = size_of(f3);
        sh = rd >> (8 * (a % 4));
        if (sz == 4) return sh;
        m = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = sh & m;
        if (!f3[2] && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    // One full request; gd = grant delay, rdly = rvalid delay (>= TMO means never).
    task automatic do_txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int gd,
                          input int rdly);
        int waits;
        bit timed_out;
        req_valid = 1'b1; req_load = ld; req_store = st; funct3 = f3; addr = a; wdata = wd;
        #1;
        if (!ld && !st) begin
            check("ignore_stall", {31'd0, stall}, 32'd0);
            next_cycle();
            req_valid = 1'b0;
            #1;
            check("ignore_busreq", {31'd0, bus_req}, 32'd0);
            check("ignore_fault", {31'd0, fault}, 32'd0);
            return;
        end
        check("accept_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        if (!is_legal(ld, st, f3, a)) begin
            #1;
            check("illegal_fault", {31'd0, fault}, 32'd1);
            check("illegal_busreq", {31'd0, bus_req}, 32'd0);
            check("illegal_stall", {31'd0, stall}, 32'd0);
            next_cycle();
            check("fault_pulse_end", {31'd0, fault}, 32'd0);
            check("fault_no_busreq", {31'd0, bus_req}, 32'd0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            bus_gnt = (i == gd);
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            #1;
            check("req_busreq", {31'd0, bus_req}, 32'd1);
            check("req_stall", {31'd0, stall}, 32'd1);
            if (i == 0) begin
                check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                check("bus_be", {28'd0, bus_be}, {28'd0, model_be(f3, a)});
                check("bus_we", {31'd0, bus_we}, {31'd0, st});
                if (st) check("bus_wdata", bus_wdata, model_wdata(f3, wd));
            end
            next_cycle();
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (st) begin
            #1;
            check("st_resp_stall", {31'd0, stall}, 32'd0);
            check("st_no_lv", {31'd0, load_valid}, 32'd0);
            check("st_busreq_off", {31'd0, bus_req}, 32'd0);
            check("st_no_fault", {31'd0, fault}, 32'd0);
            next_cycle();
            return;
        end
        timed_out = (rdly >= TMO);
        waits = timed_out ? TMO : rdly + 1;
        for (int j = 0; j < waits; j++) begin
            bus_rvalid = (j == rdly);
            bus_rdata = (j == rdly) ? rd : $urandom;
            #1;
            check("wait_stall", {31'd0, stall}, 32'd1);
            check("wait_busreq", {31'd0, bus_req}, 32'd0);
            next_cycle();
        end
        bus_rvalid = 1'b0;
        #1;
        check("resp_stall", {31'd0, stall}, 32'd0);
        if (timed_out) begin
            check("timeout_fault", {31'd0, fault}, 32'd1);
            check("timeout_no_lv", {31'd0, load_valid}, 32'd0);
        end else begin
            check("ld_valid", {31'd0, load_valid}, 32'd1);
            check("ld_data", load_data, model_load(f3, a, rd));
            check("ld_no_fault", {31'd0, fault}, 32'd0);
        end
        next_cycle();
        check("resp_lv_end", {31'd0, load_valid}, 32'd0);
        check("resp_fault_end", {31'd0, fault}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busreq"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_be"}, {28'd0, bus_be}, 32'd0);
        check({tag, "_addr"}, bus_addr, 32'd0);
        check({tag, "_lv"}, {31'd0, load_valid}, 32'd0);
        check({tag, "_fault"}, {31'd0, fault}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #12;
        check_all_zero("reset");
        check("reset_ldata", load_data, 32'd0);
        reset = 1'b0;
        next_cycle();

        // Directed cases.
        do_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        check("lw_literal", load_data, 32'hDEADBEEF);
        do_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF7F01, 0, 0);
        check("lb_literal", load_data, 32'hFFFFFF80);
        do_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF7F01, 1, 2);
        check("lbu_literal", load_data, 32'h00000080);
        do_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'd0, 3, 0);
        do_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0, 0);
        do_txn(1'b0, 1'b1, 3'b001, 32'h001, 32'd0, 32'd0, 0, 0);
        do_txn(1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 32'd0, 0, 0);
        do_txn(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 0, 0);
        do_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 0, 50);
        do_txn(1'b1, 1'b0, 3'b101, 32'h302, 32'd0, 32'h8001_1234, 0, 0);
        do_txn(1'b1, 1'b0, 3'b001, 32'h304, 32'd0, 32'h1234_8001, 2, TMO - 1);

        // Reset while the request is held in REQ: bus_req drops at once.
        req_valid = 1'b1; req_load = 1'b1; funct3 = 3'b010; addr = 32'h400;
        next_cycle();
        req_valid = 1'b0; req_load = 1'b0;
        #1;
        check("pre_reset_busreq", {31'd0, bus_req}, 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_req");
        #2 reset = 1'b0;
        next_cycle();

        // Reset during WAIT_R, then a late rvalid that must be ignored.
        req_valid = 1'b1; req_load = 1'b1; funct3 = 3'b010; addr = 32'h500;
        next_cycle();
        req_valid = 1'b0; req_load = 1'b0; bus_gnt = 1'b1;
        next_cycle();
        bus_gnt = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_all_zero("rst_wait");
        #2 reset = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        next_cycle();
        bus_rvalid = 1'b0;
        #1;
        check_all_zero("late_rvalid");
        next_cycle();
        check_all_zero("late_rvalid2");
        do_txn(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 32'h0BADF00D, 0, 0);

        // Randomized transactions.
        for (int n = 0; n < 300; n++) begin
            int kind = $urandom_range(0, 19);
            bit ld = (kind < 9) || (kind == 19);
            bit st = ((kind >= 9) && (kind < 18)) || (kind == 19);
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            do_txn(ld, st, f3, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, TMO + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
